// File: rtl/dac_rate_changer.sv
// Packs consecutive I/Q samples into two-sample words for the 160 MHz DAC path.
// Words queue in a small FIFO with a registered show-ahead head; a dangling half word can be flushed.
module dac_rate_changer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic               clkin320,
    input  logic               reset,
    input  logic [WIDTH-1:0]   i_in,
    input  logic [WIDTH-1:0]   q_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [2*WIDTH-1:0] i_out,
    output logic [2*WIDTH-1:0] q_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        pair_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HALF  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_pend;
    logic               w_pend_nxt;
    logic [WIDTH-1:0]   r_hold_i;
    logic [WIDTH-1:0]   r_hold_q;
    logic [2*WIDTH-1:0] r_mem_i [DEPTH];
    logic [2*WIDTH-1:0] r_mem_q [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_i_out;
    logic [2*WIDTH-1:0] r_q_out;
    logic [31:0]        r_pair_count;

    logic               w_full;
    logic               w_accept;
    logic               w_pop;
    logic               w_push;
    logic               w_load_hold;
    logic [2*WIDTH-1:0] w_push_i;
    logic [2*WIDTH-1:0] w_push_q;
    logic [AW-1:0]      w_rd_nxt;
    logic [CW-1:0]      w_count_nxt;

    // in_ready depends only on registered state, never on out_ready.
    assign w_full    = (r_count == CW'(DEPTH));
    assign in_ready  = ~r_pend & ((r_state == S_EMPTY) | ~w_full);
    assign out_valid = (r_count != '0);
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clkin320) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_load_hold = 1'b0;
        w_push      = 1'b0;
        w_push_i    = {i_in, r_hold_i};
        w_push_q    = {q_in, r_hold_q};
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_load_hold = 1'b1;
                    w_state_nxt = S_HALF;
                end
            end
            S_HALF: begin
                if (w_accept) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_EMPTY;
                end else if (flush | r_pend) begin
                    // Full FIFO defers the padded push until a slot frees up.
                    if (!w_full) begin
                        w_push      = 1'b1;
                        w_push_i    = {{WIDTH{1'b0}}, r_hold_i};
                        w_push_q    = {{WIDTH{1'b0}}, r_hold_q};
                        w_state_nxt = S_EMPTY;
                        w_pend_nxt  = 1'b0;
                    end else begin
                        w_pend_nxt  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clkin320) begin
        if (reset) begin
            r_hold_i <= '0;
            r_hold_q <= '0;
        end else if (w_load_hold) begin
            r_hold_i <= i_in;
            r_hold_q <= q_in;
        end
    end

    always_ff @(posedge clkin320) begin
        if (w_push) begin
            r_mem_i[r_wr_ptr] <= w_push_i;
            r_mem_q[r_wr_ptr] <= w_push_q;
        end
    end

    always_comb begin
        w_rd_nxt    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clkin320) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_pair_count <= '0;
        end else begin
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + AW'(1);
                r_pair_count <= r_pair_count + 32'd1;
            end
        end
    end

    // Head register: a word entering an empty (or draining-to-empty) FIFO
    // bypasses the array; otherwise it is read from the next read slot.
    always_ff @(posedge clkin320) begin
        if (reset) begin
            r_i_out <= '0;
            r_q_out <= '0;
        end else if (w_count_nxt != '0) begin
            if ((r_count == '0) || ((r_count == CW'(1)) && w_pop)) begin
                r_i_out <= w_push_i;
                r_q_out <= w_push_q;
            end else begin
                r_i_out <= r_mem_i[w_rd_nxt];
                r_q_out <= r_mem_q[w_rd_nxt];
            end
        end
    end

    assign i_out      = r_i_out;
    assign q_out      = r_q_out;
    assign pair_count = r_pair_count;

endmodule
